aoi_sweep_checker: RTL and testbench

AOI_SWEEP_CHECKER -- requirements
Module: aoi_sweep_checker

---
 rtl/aoi_sweep_pkg.sv | 15 +
 rtl/aoi_ref_model.sv | 22 ++
 rtl/aoi_sweep_checker.sv | 149 ++++++++++++++
 tb/tb_aoi_sweep_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aoi_sweep_pkg.sv
// Shared types and constants for the AOI exhaustive-sweep checker.
package aoi_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam int unsigned SettleMin  = 1;
    localparam int unsigned SettleMax  = 255;
    localparam int unsigned SettleCntW = 8;

endpackage

// File: rtl/aoi_ref_model.sv
// Golden AOI function: expected = NOT(OR over groups of AND of each group's inputs).
module aoi_ref_model #(
    parameter int unsigned GROUPS  = 3,
    parameter int unsigned GROUP_W = 2
) (
    input  logic [GROUPS*GROUP_W-1:0] stim,
    output logic                      expected
);

    logic any_group_high;

    // Group order in stim does not matter for the OR, so slice from the LSB end.
    always_comb begin
        any_group_high = 1'b0;
        for (int g = 0; g < int'(GROUPS); g++) begin
            any_group_high = any_group_high | (&stim[g*GROUP_W +: GROUP_W]);
        end
    end

    assign expected = ~any_group_high;

endmodule

// File: rtl/aoi_sweep_checker.sv
// Exhaustively sweeps all 2^N input vectors of an AOI cell and counts output mismatches.
// Define STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module aoi_sweep_checker
    import aoi_sweep_pkg::*;
#(
    parameter int unsigned GROUPS  = 3,
    parameter int unsigned GROUP_W = 2,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic [GROUPS*GROUP_W-1:0] stim,
    input  logic                      dut_zn,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [CNT_W-1:0]          err_count,
    output logic [GROUPS*GROUP_W-1:0] first_fail,
    output logic                      first_fail_vld
);

    localparam int unsigned N = GROUPS * GROUP_W;
    localparam logic [SettleCntW-1:0] SettleLoad = SettleCntW'(SETTLE - 1);

    if (SETTLE < SettleMin || SETTLE > SettleMax) begin : g_settle_range
        $error("aoi_sweep_checker: SETTLE out of range");
    end

    state_e                state_q, state_d;
    logic [SettleCntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]          stim_q, stim_d;
    logic [CNT_W-1:0]      err_q, err_d;
    logic [N-1:0]          ff_q, ff_d;
    logic                  ffv_q, ffv_d;
    logic                  pass_q, pass_d;
    logic                  expected;
    logic                  mismatch;

    aoi_ref_model #(
        .GROUPS  (GROUPS),
        .GROUP_W (GROUP_W)
    ) u_ref (
        .stim     (stim_q),
        .expected (expected)
    );

    assign mismatch = (dut_zn != expected);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    stim_d  = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = SettleLoad;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSample: begin
                // Abort wins: the vector under test is not scored.
                if (abort) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!ffv_q) begin
                            ff_d  = stim_q;
                            ffv_d = 1'b1;
                        end
                    end
`ifdef STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state_d = StDone;
                        pass_d  = 1'b0;
                    end else
`endif
                    if (stim_q == '1) begin
                        state_d = StDone;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = StSettle;
                        stim_d  = stim_q + 1'b1;
                        cnt_d   = SettleLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stim_q  <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    assign stim           = stim_q;
    assign busy           = (state_q == StSettle) || (state_q == StSample);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_aoi_sweep_checker.sv
// Directed bench for aoi_sweep_checker: default AOI222, a CNT_W=4 copy and a 2x3 copy.
module tb_aoi_sweep_checker;

`ifdef STOP_ON_FAIL_EN
    localparam bit Stop = 1'b1;
`else
    localparam bit Stop = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v;
    logic [2:0] abort_v;
    int         mode0;    // 0 ideal, 1 stuck 0, 2 stuck 1, 3 inverted

    logic [5:0] stim0, ff0, stim1, ff1, stim2, ff2;
    logic       zn0, zn1, zn2;
    logic       busy0, busy1, busy2, done0, done1, done2;
    logic       pass0, pass1, pass2, ffv0, ffv1, ffv2;
    logic [7:0] err0, err2;
    logic [3:0] err1;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic aoi222(input logic [5:0] s);
        return ~((s[5] & s[4]) | (s[3] & s[2]) | (s[1] & s[0]));
    endfunction

    function automatic logic aoi33(input logic [5:0] s);
        return ~((s[5] & s[4] & s[3]) | (s[2] & s[1] & s[0]));
    endfunction

    always_comb begin
        zn0 = aoi222(stim0);
        case (mode0)
            1:       zn0 = 1'b0;
            2:       zn0 = 1'b1;
            3:       zn0 = ~aoi222(stim0);
            default: zn0 = aoi222(stim0);
        endcase
    end
    assign zn1 = ~aoi222(stim1);
    assign zn2 = aoi33(stim2);

    aoi_sweep_checker u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .stim(stim0),
        .dut_zn(zn0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail(ff0), .first_fail_vld(ffv0)
    );

    aoi_sweep_checker #(.CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .stim(stim1),
        .dut_zn(zn1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail(ff1), .first_fail_vld(ffv1)
    );

    aoi_sweep_checker #(.GROUPS(2), .GROUP_W(3), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .stim(stim2),
        .dut_zn(zn2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail(ff2), .first_fail_vld(ffv2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Returns edges from the start-sampling edge to the edge that raises done (bounded).
    task automatic sweep(input int sel, output int cyc);
        bit seen = 1'b0;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[sel] = 1'b0;
        cyc = 0;
        while (!seen && cyc < 1000) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done_of(sel)) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    initial begin
        int  cyc;
        bit  saw_done;
        rst     = 1'b1;
        start_v = '0;
        abort_v = '0;
        mode0   = 0;
        #12;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_stim", stim0, 0);
        check("rst_ffv", ffv0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Ideal AOI222
        mode0 = 0;
        sweep(0, cyc);
        check("ideal_cycles", cyc, 192);
        check("ideal_pass", pass0, 1);
        check("ideal_err", err0, 0);
        check("ideal_ffv", ffv0, 0);
        check("ideal_busy_at_done", busy0, 0);
        @(negedge clk);
        check("ideal_done_pulse", done0, 0);
        check("ideal_stim_held", stim0, 63);

        // Output stuck at 0
        mode0 = 1;
        sweep(0, cyc);
        check("sa0_cycles", cyc, Stop ? 3 : 192);
        check("sa0_err", err0, Stop ? 1 : 27);
        check("sa0_pass", pass0, 0);
        check("sa0_ff", ff0, 0);
        check("sa0_ffv", ffv0, 1);

        // Inverted output, plus saturation on the 4-bit counter copy
        mode0 = 3;
        sweep(0, cyc);
        check("inv_err", err0, Stop ? 1 : 64);
        check("inv_pass", pass0, 0);
        sweep(1, cyc);
        check("inv4_cycles", cyc, Stop ? 3 : 192);
        check("inv4_err_sat", err1, Stop ? 1 : 15);
        check("inv4_pass", pass1, 0);

        // Output stuck at 1: first miss at vector 000011
        mode0 = 2;
        sweep(0, cyc);
        check("sa1_cycles", cyc, Stop ? 12 : 192);
        check("sa1_err", err0, Stop ? 1 : 37);
        check("sa1_ff", ff0, 3);
        check("sa1_ffv", ffv0, 1);
        check("sa1_pass", pass0, 0);

        // Abort sampled at edge 51 while vector 16 is in SAMPLE
        mode0 = Stop ? 0 : 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", busy0, 1);
        abort_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_v[0] = 1'b0;
        check("abort_busy_after", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_pass", pass0, 0);
        check("abort_err_held", err0, Stop ? 0 : 9);
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done0) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_stim_held", stim0, 16);
        mode0 = 0;
        sweep(0, cyc);
        check("restart_cycles", cyc, 192);
        check("restart_pass", pass0, 1);

        // 2x3 AOI, SETTLE=1
        sweep(2, cyc);
        check("g2_cycles", cyc, 128);
        check("g2_pass", pass2, 1);
        check("g2_err", err2, 0);

        // Asynchronous reset mid-sweep
        mode0 = 2;
        @(negedge clk);
        start_v[0] = 1'b1;
        start_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        start_v[2] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_busy2", busy2, 1);
        check("pre_rst_ffv0", ffv0, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_busy2", busy2, 0);
        check("rst_mid_stim2", stim2, 0);
        check("rst_mid_pass2", pass2, 0);
        check("rst_mid_err0", err0, 0);
        check("rst_mid_ff0", ff0, 0);
        check("rst_mid_ffv0", ffv0, 0);
        check("rst_mid_done0", done0, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep(2, cyc);
        check("post_rst_cycles", cyc, 128);
        check("post_rst_pass", pass2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
